two_bit_comparator: RTL and testbench



---
 rtl/two_bit_comparator_if.sv | 21 ++
 rtl/two_bit_comparator.sv | 32 +++
 tb/tb_two_bit_comparator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/two_bit_comparator_if.sv
// Operand and result signals of the 2-bit magnitude comparator.
// master drives operands {a,b} and {c,d}; slave returns the registered e/f/g flags.
interface two_bit_comparator_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  modport master (
    output a, b, c, d,
    input  e, f, g
  );

  modport slave (
    input  a, b, c, d,
    output e, f, g
  );
endinterface

// File: rtl/two_bit_comparator.sv
// Registered unsigned compare of A={a,b} against B={c,d}: e=gt, f=eq, g=lt, one cycle latency.
// No handshake: compares every cycle; all-zero flags mean "no result" (reset only).
module two_bit_comparator (
  input  logic                  clk,
  input  logic                  rst,
  two_bit_comparator_if.slave   cmp
);

  logic gt;
  logic eq;
  logic lt;

  // MSB difference decides; LSBs only matter when the MSBs agree.
  always_comb begin
    gt = (cmp.a & ~cmp.c) | (~(cmp.a ^ cmp.c) & cmp.b & ~cmp.d);
    eq = ~(cmp.a ^ cmp.c) & ~(cmp.b ^ cmp.d);
    lt = ~gt & ~eq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp.e <= 1'b0;
      cmp.f <= 1'b0;
      cmp.g <= 1'b0;
    end else begin
      cmp.e <= gt;
      cmp.f <= eq;
      cmp.g <= lt;
    end
  end

endmodule

// File: tb/tb_two_bit_comparator.sv
// Directed bench for two_bit_comparator: reset, exhaustive sweep, diagonal, MSB dominance,
// mid-stream reset and mid-cycle operand changes.
module tb_two_bit_comparator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cnt_e;
  int   cnt_f;
  int   cnt_g;

  two_bit_comparator_if bus ();

  two_bit_comparator dut (
    .clk (clk),
    .rst (rst),
    .cmp (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {bus.e, bus.f, bus.g};
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed efg=%b expected efg=%b", tag, obs, exp);
    end
  endtask

  task automatic check_onehot(input string tag);
    logic [2:0] obs;
    obs = {bus.e, bus.f, bus.g};
    n_checks++;
    assert ($onehot(obs))
    else begin
      n_fail++;
      $error("FAIL %s: observed efg=%b expected one-hot", tag, obs);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed count=%0d expected count=%0d", tag, obs, exp);
    end
  endtask

  // Drive operands at the falling edge, sample 1 ns after the next rising edge.
  task automatic apply(input logic [1:0] op_a, input logic [1:0] op_b);
    @(negedge clk);
    {bus.a, bus.b} = op_a;
    {bus.c, bus.d} = op_b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp;
    logic [1:0] va;
    logic [1:0] vb;
    n_checks = 0;
    n_fail   = 0;
    cnt_e    = 0;
    cnt_f    = 0;
    cnt_g    = 0;

    // Reset held for two edges with A=3, B=0 on the operands
    rst   = 1'b1;
    bus.a = 1'b1;
    bus.b = 1'b1;
    bus.c = 1'b0;
    bus.d = 1'b0;
    @(posedge clk); #1;
    check("reset_edge1", 3'b000);
    @(posedge clk); #1;
    check("reset_edge2", 3'b000);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_gt", 3'b100);

    // Exhaustive sweep, reference from integer comparison
    for (int v = 0; v < 16; v++) begin
      va = v[3:2];
      vb = v[1:0];
      apply(va, vb);
      exp = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
      check($sformatf("sweep_%0d%0d", va, vb), exp);
      cnt_e += int'(bus.e);
      cnt_f += int'(bus.f);
      cnt_g += int'(bus.g);
    end
    check_count("sweep_gt_count", cnt_e, 6);
    check_count("sweep_eq_count", cnt_f, 4);
    check_count("sweep_lt_count", cnt_g, 6);

    // Equality diagonal
    apply(2'd0, 2'd0); check("diag_0", 3'b010);
    apply(2'd1, 2'd1); check("diag_1", 3'b010);
    apply(2'd2, 2'd2); check("diag_2", 3'b010);
    apply(2'd3, 2'd3); check("diag_3", 3'b010);

    // Extremes and MSB dominance
    apply(2'd3, 2'd0); check("a3_b0", 3'b100);
    apply(2'd0, 2'd3); check("a0_b3", 3'b001);
    apply(2'd2, 2'd1); check("msb_a2_b1", 3'b100);
    apply(2'd1, 2'd2); check("msb_a1_b2", 3'b001);

    // Mid-stream reset: A=3,B=0 presented together with rst -> no stale e
    apply(2'd0, 2'd3); check("pre_rst_lt", 3'b001);
    @(negedge clk);
    {bus.a, bus.b} = 2'd3;
    {bus.c, bus.d} = 2'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cleared", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_release_gt", 3'b100);

    // Mid-cycle operand change must not reach the outputs before the next edge
    apply(2'd1, 2'd0); check("glitch_a1_b0", 3'b100);
    check_onehot("onehot_c0");
    #2 bus.d = 1'b1;
    #1 check("glitch_hold_gt", 3'b100);
    @(posedge clk); #1;
    check("glitch_a1_b1", 3'b010);
    check_onehot("onehot_c1");
    #2 bus.d = 1'b0;
    #1 check("glitch_hold_eq", 3'b010);
    @(posedge clk); #1;
    check("glitch_back_gt", 3'b100);
    check_onehot("onehot_c2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
